mux_scan_ctrl: RTL and testbench
================================

Name: mux_scan_ctrl

Overview:
- Sequencer that drives the 8:1 multiplexer (i_code / i_sel_code / i_en inputs) and consumes its o_f output.
- Accepts an 8-bit word over a valid/ready handshake and presents it on the mux data lines.
- Steps the select code 0..7, samples the mux output once per select, and reassembles the word.
- Flags any mismatch between the sent and received words; serves as the mux's in-system loopback checker.

Parameters:
BIT_TICKS, 1, clock cycles each select code is held; legal range 1..255, 0 is treated as 1
TICK_W, 8, width of the internal tick counter; must hold BIT_TICKS-1

Ports:
i_clk  in  1  system clock, all logic on rising edge
i_rst  in  1  synchronous, active-high reset
i_valid  in  1  upstream word available
i_word  in  8  word to scan; latched on accept
o_ready  out  1  high only in IDLE; accept = i_valid & o_ready
i_abort  in  1  cancel an in-progress scan
o_code  out  8  to mux i_code; holds the latched word
o_sel_code  out  3  to mux i_sel_code
o_en  out  1  to mux i_en; high only while scanning
i_f  in  1  from mux o_f
o_data  out  8  reassembled word; holds until the next completion
o_data_valid  out  1  one-cycle pulse when o_data updates
o_err  out  1  registered with o_data_valid: o_data != latched word; holds with o_data
o_busy  out  1  high in SCAN and DONE

Behaviour:
- Single clock domain: i_clk. Reset is synchronous and active-high on i_rst.
- Reset values: state=IDLE, o_code=0, o_sel_code=0, o_en=0, o_data=0, o_data_valid=0, o_err=0, o_busy=0, tick=0, capture register=0. o_ready=1 from the first cycle after reset.
- FSM states: IDLE, SCAN, DONE.
- IDLE:
  - o_ready=1.
  - On accept at cycle T: latch i_word into o_code, clear the capture register, set sel=0, tick=0.
  - Enter SCAN at T+1 with o_en=1.
- SCAN:
  - Each sel value is held BIT_TICKS cycles.
  - When tick==BIT_TICKS-1: sample i_f into capture[sel] (direct bit index), reset tick to 0, increment sel. Otherwise tick++.
  - Sampling at the last tick gives the combinational mux path a full period to settle.
  - After capturing sel=7: go to DONE. o_en=0 and o_sel_code wraps to 0 in that same cycle.
- DONE (exactly one cycle):
  - o_data = capture, including bit 7 captured on the previous edge.
  - o_data_valid=1; o_err = (capture != o_code).
  - Next state is IDLE.
- Latency: accept to o_data_valid = 8*BIT_TICKS+1 cycles. Throughput: one word per 8*BIT_TICKS+2 cycles.
- i_valid while not IDLE: ignored, no latch. Upstream must hold i_valid and i_word until accepted.
- i_abort:
  - In SCAN: next state IDLE, o_en=0, sel=0. No o_data_valid; o_data and o_err unchanged.
  - In IDLE or DONE: no effect. DONE still pulses.
- i_abort and i_valid in the same IDLE cycle: accept proceeds and abort is ignored.
- i_rst has priority over everything. Reset mid-SCAN returns to the reset values next cycle with no pulse.
- o_code is stable for the whole scan; it changes only on accept.

Decomposition:
- Shared package: state encoding constants (IDLE=2'd0, SCAN=2'd1, DONE=2'd2), SEL_LAST=3'd7, word width 8.
- One sub-module, bit_tick_counter: counts 0..BIT_TICKS-1, with a synchronous clear and a terminal-count output.
- The FSM, select counter and capture register stay in mux_scan_ctrl.

Test Plan:
1. BIT_TICKS=1, real 8:1 mux looped back, accept 0xA5 at T -> o_sel_code 0..7 on T+1..T+8, o_data_valid pulse at T+9, o_data=0xA5, o_err=0, o_ready=1 at T+10.
2. i_f tied 0, accept 0xFF -> o_data=0x00, o_err=1. Then i_f tied 1, accept 0x00 -> o_data=0xFF, o_err=1.
3. BIT_TICKS=4, accept 0x3C -> each sel held exactly 4 cycles, o_data_valid at accept+33, o_data=0x3C.
4. Abort asserted while o_sel_code=3 -> o_en=0 and o_ready=1 the next cycle, no o_data_valid, o_data keeps its previous value. A following accept of 0x81 completes correctly.
5. i_valid held high with changing i_word during a scan -> only the word present at the accept cycle is scanned; the next word is accepted one cycle after the DONE pulse.
6. i_rst pulsed at sel=5 mid-scan -> all outputs at reset values next cycle, no pulse. The next accept of 0x5A completes with o_err=0.

Source files
------------

// File: rtl/mux_scan_ctrl_pkg.sv
// mux_scan_ctrl_pkg: shared types and constants for the mux scan controller.
// Provides the FSM state encoding, the select range and the word width.
package mux_scan_ctrl_pkg;
    localparam int WORD_W = 8;
    localparam int SEL_W = 3;
    localparam logic [SEL_W-1:0] SEL_LAST = 3'd7;
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;
endpackage

// File: rtl/mux_scan_ctrl_if.sv
// mux_scan_ctrl_if: bundle of the word handshake, mux drive and result signals.
// slave  - the controller: takes i_valid/i_word/i_abort/i_f, drives the o_* signals.
// master - the upstream/mux side: drives i_*, observes o_*.
interface mux_scan_ctrl_if;
    import mux_scan_ctrl_pkg::*;
    logic              i_valid;
    logic [WORD_W-1:0] i_word;
    logic              o_ready;
    logic              i_abort;
    logic [WORD_W-1:0] o_code;
    logic [SEL_W-1:0]  o_sel_code;
    logic              o_en;
    logic              i_f;
    logic [WORD_W-1:0] o_data;
    logic              o_data_valid;
    logic              o_err;
    logic              o_busy;
    modport slave (
        input  i_valid, i_word, i_abort, i_f,
        output o_ready, o_code, o_sel_code, o_en, o_data, o_data_valid, o_err, o_busy
    );
    modport master (
        output i_valid, i_word, i_abort, i_f,
        input  o_ready, o_code, o_sel_code, o_en, o_data, o_data_valid, o_err, o_busy
    );
endinterface

// File: rtl/mux_scan_ctrl_bit_tick_counter.sv
// bit_tick_counter: counts 0..BIT_TICKS-1 and flags the terminal count.
// Ports: i_clk, i_rst (sync, active-high), i_clr (sync clear), o_tc (count at last tick).
module bit_tick_counter #(
    parameter int BIT_TICKS = 1,
    parameter int TICK_W = 8
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_clr,
    output logic o_tc
);
    // A BIT_TICKS of 0 behaves like 1: terminal count every cycle.
    localparam logic [TICK_W-1:0] LAST = TICK_W'(BIT_TICKS < 2 ? 0 : BIT_TICKS - 1);
    logic [TICK_W-1:0] count_q;
    assign o_tc = count_q == LAST;
    always_ff @(posedge i_clk) begin
        if (i_rst || i_clr) count_q <= '0;
        else count_q <= o_tc ? '0 : count_q + 1'b1;
    end
endmodule

// File: rtl/mux_scan_ctrl.sv
// mux_scan_ctrl: drives an 8:1 mux through all selects and rebuilds the word from its output.
// Ports: i_clk, i_rst (sync, active-high), ctrl (slave modport: word handshake,
// abort, mux drive o_code/o_sel_code/o_en, mux return i_f, result o_data/o_data_valid/o_err, o_busy).
module mux_scan_ctrl
    import mux_scan_ctrl_pkg::*;
#(
    parameter int BIT_TICKS = 1,
    parameter int TICK_W = 8
) (
    input  logic           i_clk,
    input  logic           i_rst,
    mux_scan_ctrl_if.slave ctrl
);
    state_t            state_q;
    logic [WORD_W-1:0] code_q;
    logic [WORD_W-1:0] cap_q;
    logic [WORD_W-1:0] cap_d;
    logic [WORD_W-1:0] data_q;
    logic [SEL_W-1:0]  sel_q;
    logic              en_q;
    logic              dv_q;
    logic              err_q;
    logic              tick_clr;
    logic              tick_tc;
    // Counter only runs in SCAN; holding it clear elsewhere makes every scan start at tick 0.
    assign tick_clr = state_q != SCAN || ctrl.i_abort;
    bit_tick_counter #(
        .BIT_TICKS(BIT_TICKS),
        .TICK_W(TICK_W)
    ) u_tick (
        .i_clk(i_clk),
        .i_rst(i_rst),
        .i_clr(tick_clr),
        .o_tc(tick_tc)
    );
    // Capture with the current mux bit inserted, so the result can include bit 7 on the same edge.
    always_comb begin
        cap_d = cap_q;
        cap_d[sel_q] = ctrl.i_f;
    end
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= IDLE;
            code_q  <= '0;
            cap_q   <= '0;
            data_q  <= '0;
            sel_q   <= '0;
            en_q    <= 1'b0;
            dv_q    <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (ctrl.i_valid) begin
                    code_q  <= ctrl.i_word;
                    cap_q   <= '0;
                    sel_q   <= '0;
                    en_q    <= 1'b1;
                    state_q <= SCAN;
                end
                SCAN: if (ctrl.i_abort) begin
                    sel_q   <= '0;
                    en_q    <= 1'b0;
                    state_q <= IDLE;
                end else if (tick_tc) begin
                    cap_q <= cap_d;
                    sel_q <= sel_q + 1'b1;
                    if (sel_q == SEL_LAST) begin
                        en_q    <= 1'b0;
                        data_q  <= cap_d;
                        err_q   <= cap_d != code_q;
                        dv_q    <= 1'b1;
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    dv_q    <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
    assign ctrl.o_ready      = state_q == IDLE;
    assign ctrl.o_busy       = state_q != IDLE;
    assign ctrl.o_code       = code_q;
    assign ctrl.o_sel_code   = sel_q;
    assign ctrl.o_en         = en_q;
    assign ctrl.o_data       = data_q;
    assign ctrl.o_data_valid = dv_q;
    assign ctrl.o_err        = err_q;
endmodule

// File: tb/tb_mux_scan_ctrl.sv
// tb_mux_scan_ctrl: randomized self-checking bench for mux_scan_ctrl with a behavioural mux model.
module tb_mux_scan_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int checks = 0;
    int errors = 0;
    logic [7:0] f_mask = 8'h00;
    logic [7:0] b_mask = 8'h00;
    logic f_stuck = 1'b0;
    logic f_val = 1'b0;
    mux_scan_ctrl_if a ();
    mux_scan_ctrl_if b ();
    always #5 clk = ~clk;
    // Mux model: selected code bit, optionally corrupted by a fault mask or stuck at a level.
    assign a.i_f = f_stuck ? f_val : a.o_en & (a.o_code[a.o_sel_code] ^ f_mask[a.o_sel_code]);
    assign b.i_f = b.o_en & (b.o_code[b.o_sel_code] ^ b_mask[b.o_sel_code]);
    mux_scan_ctrl #(.BIT_TICKS(1), .TICK_W(8)) dut_a (.i_clk(clk), .i_rst(rst), .ctrl(a.slave));
    mux_scan_ctrl #(.BIT_TICKS(4), .TICK_W(8)) dut_b (.i_clk(clk), .i_rst(rst), .ctrl(b.slave));

    function automatic logic [14:0] obs_a();
        return {a.o_en, a.o_sel_code, a.o_code, a.o_data_valid, a.o_busy, a.o_ready};
    endfunction
    function automatic logic [14:0] obs_b();
        return {b.o_en, b.o_sel_code, b.o_code, b.o_data_valid, b.o_busy, b.o_ready};
    endfunction
    function automatic logic [23:0] rv_a();
        return {a.o_code, a.o_sel_code, a.o_en, a.o_data, a.o_data_valid, a.o_err, a.o_busy, a.o_ready};
    endfunction
    function automatic logic [23:0] rv_b();
        return {b.o_code, b.o_sel_code, b.o_en, b.o_data, b.o_data_valid, b.o_err, b.o_busy, b.o_ready};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Full scan on dut_a (BIT_TICKS=1); expected word derived from the mux fault model.
    task automatic scan_a(input logic [7:0] w, input bit abort_edges, input string tag);
        logic [7:0] exp_data;
        logic exp_err;
        exp_data = f_stuck ? {8{f_val}} : w ^ f_mask;
        exp_err = exp_data != w;
        a.i_valid = 1'b1;
        a.i_word = w;
        a.i_abort = abort_edges;
        step();
        a.i_valid = 1'b0;
        a.i_word = 8'($urandom);
        a.i_abort = 1'b0;
        for (int k = 0; k < 8; k++) begin
            checks++;
            if (obs_a() !== {1'b1, 3'(k), w, 1'b0, 1'b1, 1'b0}) begin
                errors++;
                $display("FAIL %s scan k=%0d got %h want %h", tag, k, obs_a(), {1'b1, 3'(k), w, 1'b0, 1'b1, 1'b0});
            end
            step();
        end
        checks++;
        if ({a.o_data_valid, a.o_data, a.o_err, a.o_en, a.o_sel_code, a.o_busy, a.o_ready} !== {1'b1, exp_data, exp_err, 1'b0, 3'd0, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL %s done dv=%b data=%h err=%b en=%b sel=%0d want data=%h err=%b", tag, a.o_data_valid, a.o_data, a.o_err, a.o_en, a.o_sel_code, exp_data, exp_err);
        end
        a.i_abort = abort_edges;
        step();
        a.i_abort = 1'b0;
        checks++;
        if ({a.o_data_valid, a.o_data, a.o_err, a.o_ready, a.o_busy, a.o_en} !== {1'b0, exp_data, exp_err, 1'b1, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL %s idle dv=%b data=%h err=%b ready=%b want data=%h err=%b ready=1", tag, a.o_data_valid, a.o_data, a.o_err, a.o_ready, exp_data, exp_err);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        a.i_valid = 1'b1;
        a.i_word = 8'hC3;
        a.i_abort = 1'b0;
        b.i_valid = 1'b1;
        b.i_word = 8'h3C;
        b.i_abort = 1'b0;
        repeat (3) step();
        checks++;
        if (rv_a() !== 24'h000001 || rv_b() !== 24'h000001) begin
            errors++;
            $display("FAIL reset_hold a=%h b=%h want 000001", rv_a(), rv_b());
        end
        a.i_valid = 1'b0;
        b.i_valid = 1'b0;
        rst = 1'b0;
        step();
        checks++;
        if (rv_a() !== 24'h000001 || rv_b() !== 24'h000001) begin
            errors++;
            $display("FAIL reset_release a=%h b=%h want 000001", rv_a(), rv_b());
        end
    endtask

    task automatic test_loopback();
        logic [7:0] w;
        f_stuck = 1'b0;
        f_mask = 8'h00;
        scan_a(8'hA5, 1'b0, "loop_a5");
        for (int i = 0; i < 6; i++) begin
            w = 8'($urandom);
            f_mask = $urandom_range(0, 1) ? 8'h00 : 8'($urandom);
            scan_a(w, 1'b0, "loop_rand");
        end
        f_mask = 8'h00;
    endtask

    task automatic test_stuck();
        f_stuck = 1'b1;
        f_val = 1'b0;
        scan_a(8'hFF, 1'b0, "stuck0");
        f_val = 1'b1;
        scan_a(8'h00, 1'b0, "stuck1");
        f_stuck = 1'b0;
    endtask

    task automatic test_bit_ticks();
        logic [7:0] w;
        logic [7:0] exp_data;
        for (int i = 0; i < 2; i++) begin
            w = i == 0 ? 8'h3C : 8'($urandom);
            b_mask = i == 0 ? 8'h00 : 8'($urandom);
            exp_data = w ^ b_mask;
            b.i_valid = 1'b1;
            b.i_word = w;
            step();
            b.i_valid = 1'b0;
            for (int k = 0; k < 8; k++)
                for (int t = 0; t < 4; t++) begin
                    checks++;
                    if (obs_b() !== {1'b1, 3'(k), w, 1'b0, 1'b1, 1'b0}) begin
                        errors++;
                        $display("FAIL ticks4 k=%0d t=%0d got %h want %h", k, t, obs_b(), {1'b1, 3'(k), w, 1'b0, 1'b1, 1'b0});
                    end
                    step();
                end
            checks++;
            if ({b.o_data_valid, b.o_data, b.o_err, b.o_en} !== {1'b1, exp_data, exp_data != w, 1'b0}) begin
                errors++;
                $display("FAIL ticks4_done dv=%b data=%h err=%b want data=%h err=%b", b.o_data_valid, b.o_data, b.o_err, exp_data, exp_data != w);
            end
            step();
            checks++;
            if ({b.o_data_valid, b.o_ready} !== 2'b01) begin
                errors++;
                $display("FAIL ticks4_idle dv=%b ready=%b want dv=0 ready=1", b.o_data_valid, b.o_ready);
            end
        end
        b_mask = 8'h00;
    endtask

    task automatic test_abort();
        scan_a(8'h96, 1'b0, "pre_abort");
        a.i_valid = 1'b1;
        a.i_word = 8'h42;
        step();
        a.i_valid = 1'b0;
        repeat (3) step();
        checks++;
        if (a.o_sel_code !== 3'd3) begin
            errors++;
            $display("FAIL abort_setup sel=%0d want 3", a.o_sel_code);
        end
        a.i_abort = 1'b1;
        step();
        a.i_abort = 1'b0;
        checks++;
        if ({a.o_en, a.o_ready, a.o_busy, a.o_sel_code} !== {1'b0, 1'b1, 1'b0, 3'd0}) begin
            errors++;
            $display("FAIL abort_next en=%b ready=%b busy=%b sel=%0d want 0 1 0 0", a.o_en, a.o_ready, a.o_busy, a.o_sel_code);
        end
        for (int i = 0; i < 12; i++) begin
            checks++;
            if ({a.o_data_valid, a.o_data, a.o_err} !== {1'b0, 8'h96, 1'b0}) begin
                errors++;
                $display("FAIL abort_quiet cyc=%0d dv=%b data=%h err=%b want dv=0 data=96 err=0", i, a.o_data_valid, a.o_data, a.o_err);
            end
            step();
        end
        scan_a(8'h81, 1'b1, "after_abort");
    endtask

    task automatic test_back_to_back();
        logic [7:0] w1;
        logic [7:0] w2;
        w1 = 8'($urandom);
        w2 = ~w1;
        a.i_valid = 1'b1;
        a.i_word = w1;
        step();
        for (int k = 0; k < 8; k++) begin
            a.i_word = 8'($urandom);
            checks++;
            if (obs_a() !== {1'b1, 3'(k), w1, 1'b0, 1'b1, 1'b0}) begin
                errors++;
                $display("FAIL b2b_scan k=%0d got %h want %h", k, obs_a(), {1'b1, 3'(k), w1, 1'b0, 1'b1, 1'b0});
            end
            step();
        end
        checks++;
        if ({a.o_data_valid, a.o_data, a.o_err} !== {1'b1, w1, 1'b0}) begin
            errors++;
            $display("FAIL b2b_done1 dv=%b data=%h err=%b want data=%h", a.o_data_valid, a.o_data, a.o_err, w1);
        end
        a.i_word = w2;
        step();
        checks++;
        if ({a.o_ready, a.o_data_valid, a.o_code} !== {1'b1, 1'b0, w1}) begin
            errors++;
            $display("FAIL b2b_gap ready=%b dv=%b code=%h want ready=1 code=%h", a.o_ready, a.o_data_valid, a.o_code, w1);
        end
        step();
        a.i_valid = 1'b0;
        checks++;
        if (obs_a() !== {1'b1, 3'd0, w2, 1'b0, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL b2b_accept2 got %h want %h", obs_a(), {1'b1, 3'd0, w2, 1'b0, 1'b1, 1'b0});
        end
        repeat (8) step();
        checks++;
        if ({a.o_data_valid, a.o_data, a.o_err} !== {1'b1, w2, 1'b0}) begin
            errors++;
            $display("FAIL b2b_done2 dv=%b data=%h err=%b want data=%h", a.o_data_valid, a.o_data, a.o_err, w2);
        end
        step();
    endtask

    task automatic test_reset_mid();
        a.i_valid = 1'b1;
        a.i_word = 8'h33;
        step();
        a.i_valid = 1'b0;
        repeat (5) step();
        checks++;
        if (a.o_sel_code !== 3'd5) begin
            errors++;
            $display("FAIL rstmid_setup sel=%0d want 5", a.o_sel_code);
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        checks++;
        if (rv_a() !== 24'h000001 || rv_b() !== 24'h000001) begin
            errors++;
            $display("FAIL rstmid_values a=%h b=%h want 000001", rv_a(), rv_b());
        end
        for (int i = 0; i < 5; i++) begin
            checks++;
            if ({a.o_data_valid, a.o_busy} !== 2'b00) begin
                errors++;
                $display("FAIL rstmid_quiet cyc=%0d dv=%b busy=%b want 0 0", i, a.o_data_valid, a.o_busy);
            end
            step();
        end
        scan_a(8'h5A, 1'b0, "post_rst");
    endtask

    initial begin
        test_reset();
        test_loopback();
        test_stuck();
        test_bit_ticks();
        test_abort();
        test_back_to_back();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
